// File: rtl/sd_crc_engine.sv
// sd_crc_engine
// Parametrised CRC generator/checker for the SD link (CRC7 on CMD, CRC16 per DAT line).
// Accumulates LANES independent CRCs, DATA_W bits per lane per beat, MSB first, then
// either emits each lane's CRC serially under a valid/ready handshake or exposes a
// per-lane zero-residue flag for check mode (data followed by the received CRC).

module sd_crc_engine #(
   parameter int               CRC_W  = 7,
   parameter logic [CRC_W-1:0] POLY   = 7'h09,
   parameter int               DATA_W = 1,
   parameter int               LANES  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    crc_valid,
   output logic [LANES*CRC_W-1:0]  crc_out,
   output logic [LANES-1:0]        crc_zero,
   input  logic                    emit_req,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES-1:0]        out_data,
   output logic                    out_last
);

   localparam int CNT_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;

   typedef enum logic [1:0] {
      S_ACC,
      S_HOLD,
      S_EMIT
   } state_t;

   state_t           state_q, state_d;
   logic [CRC_W-1:0] crc_q [LANES];
   logic [CRC_W-1:0] crc_d [LANES];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // One beat of the serial LFSR update, applied DATA_W times with the MSB entering first.
   // Shifting with << keeps the update valid for any CRC width and zero fills bit 0.
   function automatic logic [CRC_W-1:0] crcBeat(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] r;
      logic             fb;
      r = c;
      for (int b = DATA_W - 1; b >= 0; b--) begin
         fb = d[b] ^ r[CRC_W-1];
         r  = (r << 1) ^ (fb ? POLY : '0);
      end
      return r;
   endfunction

   // Next-state logic: accumulate in S_ACC, wait in S_HOLD, shift out in S_EMIT.
   // clear overrides everything here, dropping any same-cycle beat or handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < LANES; i++) begin
         crc_d[i] = crc_q[i];
      end

      case (state_q)
         S_ACC: begin
            if (in_valid) begin
               for (int i = 0; i < LANES; i++) begin
                  crc_d[i] = crcBeat(crc_q[i], in_data[i*DATA_W +: DATA_W]);
               end
               if (in_last) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (emit_req) begin
               state_d = S_EMIT;
               cnt_d   = CNT_W'(CRC_W - 1);
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               for (int i = 0; i < LANES; i++) begin
                  crc_d[i] = crc_q[i] << 1;
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_d = S_ACC;
                  cnt_d   = '0;
                  for (int i = 0; i < LANES; i++) begin
                     crc_d[i] = '0;
                  end
               end
            end
         end
         default: begin
            state_d = S_ACC;
         end
      endcase

      if (clear) begin
         state_d = S_ACC;
         cnt_d   = '0;
         for (int i = 0; i < LANES; i++) begin
            crc_d[i] = '0;
         end
      end
   end

   // State, bit counter and CRC registers; synchronous reset has priority over clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_ACC;
         cnt_q   <= '0;
         for (int i = 0; i < LANES; i++) begin
            crc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < LANES; i++) begin
            crc_q[i] <= crc_d[i];
         end
      end
   end

   // Outputs are pure decodes of the registered state, so they change only on clock edges.
   always_comb begin
      in_ready  = (state_q == S_ACC);
      crc_valid = (state_q == S_HOLD);
      out_valid = (state_q == S_EMIT);
      out_last  = (state_q == S_EMIT) && (cnt_q == '0);
      crc_out   = '0;
      crc_zero  = '0;
      out_data  = '0;
      for (int i = 0; i < LANES; i++) begin
         crc_out[i*CRC_W +: CRC_W] = crc_q[i];
         crc_zero[i]               = (crc_q[i] == '0);
         out_data[i]               = (state_q == S_EMIT) ? crc_q[i][CRC_W-1] : 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_crc_engine.sv
// tb_sd_crc_engine
// Directed bench for sd_crc_engine with two instances: a CMD CRC7 engine taking bytes,
// and a 4-lane DAT CRC16 engine taking one nibble per lane per beat.

module tb_sd_crc_engine;

   logic clk;
   logic reset;

   // CRC7, 8 bits per beat, one lane
   logic        aClear, aInValid, aInLast, aEmitReq, aOutReady;
   logic [7:0]  aInData;
   logic        aInReady, aCrcValid, aOutValid, aOutLast;
   logic [6:0]  aCrcOut;
   logic [0:0]  aCrcZero, aOutData;

   // CRC16, 4 bits per beat, four lanes
   logic        cClear, cInValid, cInLast, cEmitReq, cOutReady;
   logic [15:0] cInData;
   logic        cInReady, cCrcValid, cOutValid, cOutLast;
   logic [63:0] cCrcOut;
   logic [3:0]  cCrcZero, cOutData;

   int total = 0;
   int bad   = 0;

   sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .DATA_W(8), .LANES(1)) uA (
      .clk(clk), .reset(reset), .clear(aClear),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_last(aInLast),
      .crc_valid(aCrcValid), .crc_out(aCrcOut), .crc_zero(aCrcZero),
      .emit_req(aEmitReq), .out_valid(aOutValid), .out_ready(aOutReady),
      .out_data(aOutData), .out_last(aOutLast)
   );

   sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .DATA_W(4), .LANES(4)) uC (
      .clk(clk), .reset(reset), .clear(cClear),
      .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData), .in_last(cInLast),
      .crc_valid(cCrcValid), .crc_out(cCrcOut), .crc_zero(cCrcZero),
      .emit_req(cEmitReq), .out_valid(cOutValid), .out_ready(cOutReady),
      .out_data(cOutData), .out_last(cOutLast)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bit-serial CRC7 reference, one byte MSB first
   function automatic logic [6:0] refCrc7(input logic [6:0] c, input logic [7:0] d);
      logic [6:0] r;
      logic       fb;
      r = c;
      for (int b = 7; b >= 0; b--) begin
         fb = d[b] ^ r[6];
         r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One input beat on instance 0 (CRC7) or 1 (CRC16 x4)
   task automatic applyStimulus(input int inst, input logic [15:0] d, input logic last);
      if (inst == 0) begin
         aInValid = 1'b1; aInData = d[7:0]; aInLast = last;
         tick();
         aInValid = 1'b0; aInData = '0; aInLast = 1'b0;
      end else begin
         cInValid = 1'b1; cInData = d; cInLast = last;
         tick();
         cInValid = 1'b0; cInData = '0; cInLast = 1'b0;
      end
   endtask

   task automatic pulseClearA();
      aClear = 1'b1;
      tick();
      aClear = 1'b0;
   endtask

   initial begin
      logic [6:0]  expA;
      logic [6:0]  crc7Word;
      logic [15:0] crc16Word;
      logic [7:0]  rnd;
      int          len;

      reset = 1'b1;
      aClear = 0; aInValid = 0; aInLast = 0; aEmitReq = 0; aOutReady = 0; aInData = '0;
      cClear = 0; cInValid = 0; cInLast = 0; cEmitReq = 0; cOutReady = 0; cInData = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      $display("[TB] reset values");
      checkOutput("rst_in_ready", 64'(aInReady), 64'd1);
      checkOutput("rst_crc_valid", 64'(aCrcValid), 64'd0);
      checkOutput("rst_out_valid", 64'(aOutValid), 64'd0);
      checkOutput("rst_out_last", 64'(aOutLast), 64'd0);
      checkOutput("rst_out_data", 64'(aOutData), 64'd0);
      checkOutput("rst_crc_out", 64'(aCrcOut), 64'd0);
      checkOutput("rst_crc_zero", 64'(aCrcZero), 64'd1);
      checkOutput("rst_c_crc_zero", 64'(cCrcZero), 64'hF);

      // emit_req in S_ACC has no effect
      aEmitReq = 1'b1;
      tick();
      aEmitReq = 1'b0;
      checkOutput("emit_in_acc_out_valid", 64'(aOutValid), 64'd0);
      checkOutput("emit_in_acc_in_ready", 64'(aInReady), 64'd1);

      // CMD0: 40 00 00 00 00 -> 7'h4A, with an idle cycle mid frame
      $display("[TB] CMD0 CRC7 and emission");
      applyStimulus(0, 16'h40, 1'b0);
      applyStimulus(0, 16'h00, 1'b0);
      tick();
      applyStimulus(0, 16'h00, 1'b0);
      applyStimulus(0, 16'h00, 1'b0);
      applyStimulus(0, 16'h00, 1'b1);
      checkOutput("cmd0_crc", 64'(aCrcOut), 64'h4A);
      checkOutput("cmd0_crc_valid", 64'(aCrcValid), 64'd1);
      checkOutput("cmd0_in_ready", 64'(aInReady), 64'd0);
      checkOutput("cmd0_crc_zero", 64'(aCrcZero), 64'd0);

      // in_valid in S_HOLD is ignored, and the engine waits without emit_req
      applyStimulus(0, 16'hFF, 1'b1);
      tick();
      checkOutput("hold_ignore_crc", 64'(aCrcOut), 64'h4A);
      checkOutput("hold_stays", 64'(aCrcValid), 64'd1);

      aEmitReq = 1'b1;
      tick();
      aEmitReq = 1'b0;
      aOutReady = 1'b1;
      crc7Word = 7'h4A;
      for (int k = 0; k < 7; k++) begin
         checkOutput($sformatf("cmd0_emit_valid%0d", k), 64'(aOutValid), 64'd1);
         checkOutput($sformatf("cmd0_emit_bit%0d", k), 64'(aOutData), 64'(crc7Word[6-k]));
         checkOutput($sformatf("cmd0_emit_last%0d", k), 64'(aOutLast), 64'(k == 6));
         tick();
      end
      aOutReady = 1'b0;
      checkOutput("cmd0_done_out_valid", 64'(aOutValid), 64'd0);
      checkOutput("cmd0_done_in_ready", 64'(aInReady), 64'd1);
      checkOutput("cmd0_done_crc", 64'(aCrcOut), 64'd0);

      // CMD8: 48 00 00 01 AA -> 7'h43, then clear in S_HOLD alongside a beat
      $display("[TB] CMD8 CRC7 and clear");
      applyStimulus(0, 16'h48, 1'b0);
      applyStimulus(0, 16'h00, 1'b0);
      applyStimulus(0, 16'h00, 1'b0);
      applyStimulus(0, 16'h01, 1'b0);
      applyStimulus(0, 16'hAA, 1'b1);
      checkOutput("cmd8_crc", 64'(aCrcOut), 64'h43);
      aClear = 1'b1;
      tick();
      aClear = 1'b0;
      checkOutput("clr_hold_in_ready", 64'(aInReady), 64'd1);
      checkOutput("clr_hold_crc", 64'(aCrcOut), 64'd0);

      // clear with a same-cycle beat in S_ACC drops the beat
      aClear = 1'b1;
      applyStimulus(0, 16'h55, 1'b1);
      aClear = 1'b0;
      checkOutput("clr_acc_crc", 64'(aCrcOut), 64'd0);
      checkOutput("clr_acc_in_ready", 64'(aInReady), 64'd1);

      // clear after three emitted bits aborts the emission
      applyStimulus(0, 16'h40, 1'b0);
      for (int j = 0; j < 3; j++) applyStimulus(0, 16'h00, 1'b0);
      applyStimulus(0, 16'h00, 1'b1);
      checkOutput("cmd0b_crc", 64'(aCrcOut), 64'h4A);
      aEmitReq = 1'b1;
      tick();
      aEmitReq = 1'b0;
      aOutReady = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("abort_bit3", 64'(aOutData), 64'(crc7Word[3]));
      aClear = 1'b1;
      tick();
      aClear = 1'b0;
      checkOutput("abort_out_valid", 64'(aOutValid), 64'd0);
      checkOutput("abort_in_ready", 64'(aInReady), 64'd1);
      checkOutput("abort_crc", 64'(aCrcOut), 64'd0);

      // reset mid emission with out_ready high
      $display("[TB] reset during emission");
      applyStimulus(0, 16'h48, 1'b0);
      applyStimulus(0, 16'h00, 1'b1);
      aEmitReq = 1'b1;
      tick();
      aEmitReq = 1'b0;
      tick();
      reset = 1'b1;
      aClear = 1'b1;
      tick();
      reset = 1'b0;
      aClear = 1'b0;
      aOutReady = 1'b0;
      checkOutput("rst_emit_out_valid", 64'(aOutValid), 64'd0);
      checkOutput("rst_emit_out_data", 64'(aOutData), 64'd0);
      checkOutput("rst_emit_out_last", 64'(aOutLast), 64'd0);
      checkOutput("rst_emit_crc", 64'(aCrcOut), 64'd0);
      checkOutput("rst_emit_crc_zero", 64'(aCrcZero), 64'd1);
      checkOutput("rst_emit_in_ready", 64'(aInReady), 64'd1);

      // random frames against the bit-serial reference; first one is a single beat
      $display("[TB] random CRC7 frames");
      for (int f = 0; f < 5; f++) begin
         len  = (f == 0) ? 1 : int'($urandom_range(2, 6));
         expA = '0;
         for (int j = 0; j < len; j++) begin
            rnd  = 8'($urandom);
            expA = refCrc7(expA, rnd);
            applyStimulus(0, {8'h00, rnd}, (j == len - 1));
         end
         checkOutput($sformatf("rand%0d_crc", f), 64'(aCrcOut), 64'(expA));
         checkOutput($sformatf("rand%0d_valid", f), 64'(aCrcValid), 64'd1);
         pulseClearA();
      end

      // 4 lanes x 4096 ones each -> 16'h7FA1 per lane
      $display("[TB] CRC16 four lanes");
      for (int j = 0; j < 1024; j++) applyStimulus(1, 16'hFFFF, (j == 1023));
      checkOutput("ones_crc", cCrcOut, {4{16'h7FA1}});
      checkOutput("ones_crc_zero", 64'(cCrcZero), 64'h0);
      checkOutput("ones_crc_valid", 64'(cCrcValid), 64'd1);

      // emission with out_ready toggling: bits hold while stalled
      crc16Word = 16'h7FA1;
      cEmitReq = 1'b1;
      tick();
      cEmitReq = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cOutReady = 1'b0;
         tick();
         checkOutput($sformatf("c_stall_bit%0d", k), 64'(cOutData), 64'({4{crc16Word[15-k]}}));
         checkOutput($sformatf("c_stall_last%0d", k), 64'(cOutLast), 64'(k == 15));
         checkOutput($sformatf("c_stall_valid%0d", k), 64'(cOutValid), 64'd1);
         cOutReady = 1'b1;
         tick();
      end
      cOutReady = 1'b0;
      checkOutput("c_done_in_ready", 64'(cInReady), 64'd1);
      checkOutput("c_done_crc", cCrcOut, 64'd0);
      checkOutput("c_done_out_valid", 64'(cOutValid), 64'd0);

      // check mode: data followed by its CRC leaves a zero residue on every lane
      for (int j = 0; j < 1024; j++) applyStimulus(1, 16'hFFFF, 1'b0);
      applyStimulus(1, 16'h7777, 1'b0);
      applyStimulus(1, 16'hFFFF, 1'b0);
      applyStimulus(1, 16'hAAAA, 1'b0);
      applyStimulus(1, 16'h1111, 1'b1);
      checkOutput("resid_crc_zero", 64'(cCrcZero), 64'hF);
      checkOutput("resid_crc", cCrcOut, 64'd0);
      cClear = 1'b1;
      tick();
      cClear = 1'b0;

      // single-beat frame, only lane 0 sees ones: lanes stay independent
      applyStimulus(1, 16'h000F, 1'b1);
      checkOutput("lane_crc", cCrcOut, 64'h0000_0000_0000_F1EF);
      checkOutput("lane_crc_zero", 64'(cCrcZero), 64'hE);
      checkOutput("lane_crc_valid", 64'(cCrcValid), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
